// File: rtl/mul_seq_ctrl.sv
// Sequencing front-end for the 32-bit shift-add multiplier: accepts operands,
// runs the multiplier, and buffers the sign-corrected product or a timeout result.
module mul_seq_ctrl #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [31:0] In_A,
  input  logic [31:0] In_B,
  input  logic        In_Signed,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [63:0] Out_Product,
  output logic        Out_Error,
  output logic [7:0]  Out_Cycles,
  output logic [31:0] Mul_Multiplicand,
  output logic [31:0] Mul_Multiplier,
  output logic        Mul_Run,
  output logic        Mul_Reset,
  input  logic [63:0] Mul_Product,
  input  logic        Mul_Ready
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_WAIT, S_FIX, S_DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  logic        neg;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  // Two's-complement negate leaves 0x80000000 unchanged, which is its unsigned magnitude.
  always_comb begin
    mag_a = In_A;
    mag_b = In_B;
    if (In_Signed && In_A[31]) mag_a = ~In_A + 32'd1;
    if (In_Signed && In_B[31]) mag_b = ~In_B + 32'd1;
    cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state            <= S_IDLE;
      neg              <= 1'b0;
      cnt              <= '0;
      In_Ready         <= 1'b1;
      Out_Valid        <= 1'b0;
      Out_Product      <= '0;
      Out_Error        <= 1'b0;
      Out_Cycles       <= '0;
      Mul_Multiplicand <= '0;
      Mul_Multiplier   <= '0;
      Mul_Run          <= 1'b0;
      Mul_Reset        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (In_Valid) begin
            Mul_Multiplicand <= mag_a;
            Mul_Multiplier   <= mag_b;
            neg              <= In_Signed & (In_A[31] ^ In_B[31]);
            Out_Error        <= 1'b0;
            In_Ready         <= 1'b0;
            Mul_Reset        <= 1'b1;
            state            <= S_CLR;
          end
        end
        S_CLR: begin
          Mul_Reset <= 1'b0;
          Mul_Run   <= 1'b1;
          cnt       <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt_inc;
          // A Ready arriving on the timeout cycle still yields a valid product.
          if (Mul_Ready) begin
            Out_Product <= Mul_Product;
            Out_Cycles  <= cnt_inc;
            Mul_Run     <= 1'b0;
            state       <= S_FIX;
          end else if (cnt_inc >= TIMEOUT_CNT) begin
            Out_Product <= '0;
            Out_Error   <= 1'b1;
            Out_Cycles  <= cnt_inc;
            Mul_Run     <= 1'b0;
            Out_Valid   <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_FIX: begin
          if (neg) Out_Product <= ~Out_Product + 64'd1;
          Out_Valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (Out_Ready) begin
            Out_Valid <= 1'b0;
            In_Ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          In_Ready  <= 1'b1;
          Out_Valid <= 1'b0;
          Mul_Run   <= 1'b0;
          Mul_Reset <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
